// File: rtl/stack_pointer_unit_if.sv
// Bus bundle for the stack-pointer unit: operation request in, pointer and status out.
interface stack_pointer_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             RegWrite;
  logic [1:0]       Op;
  logic [WIDTH-1:0] LoadIn;
  logic             ClearFlags;
  logic [WIDTH-1:0] RegOut;
  logic             Full;
  logic             Empty;
  logic             Overflow;
  logic             Underflow;
  logic             Fault;

  // Requester side: issues operations and observes the pointer.
  modport master (
    output RegWrite, Op, LoadIn, ClearFlags,
    input  RegOut, Full, Empty, Overflow, Underflow, Fault
  );

  // Pointer side: the unit itself.
  modport slave (
    input  RegWrite, Op, LoadIn, ClearFlags,
    output RegOut, Full, Empty, Overflow, Underflow, Fault
  );
endinterface

// File: rtl/stack_pointer_unit.sv
// Parametrised stack pointer: increment/decrement by STEP, synchronous load,
// saturating or wrapping within [BASE, LIMIT], with Full/Empty status,
// sticky Overflow/Underflow and a one-cycle Fault pulse per violation.
module stack_pointer_unit #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STEP        = 1,
  parameter int unsigned BASE        = 0,
  parameter int unsigned LIMIT       = (2**WIDTH) - 1,
  parameter int unsigned RESET_VALUE = 0,
  parameter int unsigned SATURATE    = 0
) (
  input logic                 CLK,
  input logic                 Reset,
  stack_pointer_unit_if.slave bus
);

  // One extra bit so pointer +/- STEP never wraps before it is compared.
  typedef logic [WIDTH:0] extT;

  localparam extT              baseX  = extT'(BASE);
  localparam extT              limitX = extT'(LIMIT);
  localparam extT              stepX  = extT'(STEP);
  localparam logic [WIDTH-1:0] resetV = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] regOut;
  logic             overflow;
  logic             underflow;
  logic             fault;

  extT              regX;
  extT              loadX;
  logic             isFull;
  logic             isEmpty;
  logic [WIDTH-1:0] nextReg;
  logic             setOvf;
  logic             setUnf;

  // Pointer after an increment, clamped or wrapped back to BASE when it passes LIMIT.
  function automatic logic [WIDTH-1:0] incrResult(input extT cur);
    extT sum;
    sum = cur + stepX;
    if (sum <= limitX)
      return WIDTH'(sum);
    else if (SATURATE != 0)
      return WIDTH'(limitX);
    else
      return WIDTH'(baseX + (sum - limitX - extT'(1)));
  endfunction

  // Pointer after a decrement, clamped or wrapped down from LIMIT when it passes BASE.
  // The lower test is written as cur < BASE+STEP so nothing goes negative.
  function automatic logic [WIDTH-1:0] decrResult(input extT cur);
    if (cur >= baseX + stepX)
      return WIDTH'(cur - stepX);
    else if (SATURATE != 0)
      return WIDTH'(baseX);
    else
      return WIDTH'(limitX - (baseX + stepX - cur) + extT'(1));
  endfunction

  assign regX    = {1'b0, regOut};
  assign loadX   = {1'b0, bus.LoadIn};
  assign isFull  = (regX + stepX) > limitX;
  assign isEmpty = regX < (baseX + stepX);

  // Next pointer value and which bound (if any) this cycle's operation violates.
  always_comb begin
    nextReg = regOut;
    setOvf  = 1'b0;
    setUnf  = 1'b0;
    if (bus.RegWrite) begin
      case (bus.Op)
        2'b00: begin
          nextReg = incrResult(regX);
          setOvf  = isFull;
        end
        2'b01: begin
          nextReg = decrResult(regX);
          setUnf  = isEmpty;
        end
        2'b10: begin
          if (loadX > limitX)
            setOvf = 1'b1;
          else if (loadX < baseX)
            setUnf = 1'b1;
          else
            nextReg = bus.LoadIn;
        end
        default: ;
      endcase
    end
  end

  // ---- stage boundary: pointer, sticky flags and fault pulse registered ----
  // A violation in the same cycle as ClearFlags wins for the flag it sets.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      regOut    <= resetV;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      fault     <= 1'b0;
    end else begin
      regOut    <= nextReg;
      overflow  <= setOvf | (overflow  & ~bus.ClearFlags);
      underflow <= setUnf | (underflow & ~bus.ClearFlags);
      fault     <= setOvf | setUnf;
    end
  end

  assign bus.RegOut    = regOut;
  assign bus.Full      = isFull;
  assign bus.Empty     = isEmpty;
  assign bus.Overflow  = overflow;
  assign bus.Underflow = underflow;
  assign bus.Fault     = fault;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit: default wrapping pointer, a saturating
// bounded pointer (with load and priority cases) and a wrapping bounded pointer.
module tb_stack_pointer_unit;

  logic CLK = 1'b0;
  logic rstA, rstB, rstC;
  int   nCompared   = 0;
  int   nMismatched = 0;

  always #5 CLK = ~CLK;

  stack_pointer_unit_if #(.WIDTH(16)) ifA ();
  stack_pointer_unit_if #(.WIDTH(16)) ifB ();
  stack_pointer_unit_if #(.WIDTH(16)) ifC ();

  stack_pointer_unit dutA (.CLK(CLK), .Reset(rstA), .bus(ifA));

  stack_pointer_unit #(
    .WIDTH(16), .STEP(4), .BASE(16), .LIMIT(40), .RESET_VALUE(16), .SATURATE(1)
  ) dutB (.CLK(CLK), .Reset(rstB), .bus(ifB));

  stack_pointer_unit #(
    .WIDTH(16), .STEP(4), .BASE(16), .LIMIT(40), .RESET_VALUE(16), .SATURATE(0)
  ) dutC (.CLK(CLK), .Reset(rstC), .bus(ifC));

  // Count one comparison and report it if observed differs from expected.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    ifA.RegWrite = 1'b0; ifA.Op = 2'b11; ifA.LoadIn = '0; ifA.ClearFlags = 1'b0;
    ifB.RegWrite = 1'b0; ifB.Op = 2'b11; ifB.LoadIn = '0; ifB.ClearFlags = 1'b0;
    ifC.RegWrite = 1'b0; ifC.Op = 2'b11; ifC.LoadIn = '0; ifC.ClearFlags = 1'b0;
    tick();
    tick();

    // ---------------- defaults: reset state ----------------
    chk("A reset RegOut", ifA.RegOut, 0);
    chk("A reset Ovf", ifA.Overflow, 0);
    chk("A reset Unf", ifA.Underflow, 0);
    chk("A reset Fault", ifA.Fault, 0);
    chk("A reset Empty", ifA.Empty, 1);
    chk("A reset Full", ifA.Full, 0);
    rstA = 1'b0;

    // count up 1..32, then down 31..0
    ifA.RegWrite = 1'b1; ifA.Op = 2'b00;
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("A up RegOut", ifA.RegOut, i);
      chk("A up Fault", ifA.Fault, 0);
    end
    ifA.Op = 2'b01;
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("A down RegOut", ifA.RegOut, 32 - i);
      chk("A down Fault", ifA.Fault, 0);
    end

    // wrap below zero
    tick();
    chk("A wrap RegOut", ifA.RegOut, 16'hFFFF);
    chk("A wrap Unf", ifA.Underflow, 1);
    chk("A wrap Ovf", ifA.Overflow, 0);
    chk("A wrap Fault", ifA.Fault, 1);
    chk("A wrap Full", ifA.Full, 1);

    // wrap above top, then two clean increments: Fault drops after one cycle
    ifA.Op = 2'b00;
    tick();
    chk("A wrapup RegOut", ifA.RegOut, 0);
    chk("A wrapup Ovf", ifA.Overflow, 1);
    chk("A wrapup Fault", ifA.Fault, 1);
    tick();
    chk("A inc1 RegOut", ifA.RegOut, 1);
    chk("A inc1 Fault", ifA.Fault, 0);
    chk("A inc1 Unf sticky", ifA.Underflow, 1);
    tick();
    chk("A inc2 RegOut", ifA.RegOut, 2);

    // reset mid-stream wins over the increment and clears flags
    rstA = 1'b1;
    tick();
    rstA = 1'b0;
    chk("A midrst RegOut", ifA.RegOut, 0);
    chk("A midrst Ovf", ifA.Overflow, 0);
    chk("A midrst Unf", ifA.Underflow, 0);
    chk("A midrst Fault", ifA.Fault, 0);

    // underflow then ClearFlags while idle
    ifA.Op = 2'b01;
    tick();
    chk("A unf2 Unf", ifA.Underflow, 1);
    ifA.RegWrite = 1'b0; ifA.ClearFlags = 1'b1;
    tick();
    ifA.ClearFlags = 1'b0;
    chk("A clr Unf", ifA.Underflow, 0);
    chk("A clr Fault", ifA.Fault, 0);
    chk("A clr RegOut", ifA.RegOut, 16'hFFFF);

    // RegWrite=0 holds for five edges
    ifA.Op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("A hold RegOut", ifA.RegOut, 16'hFFFF);
    end
    // Op=11 also holds
    ifA.RegWrite = 1'b1; ifA.Op = 2'b11;
    tick();
    chk("A op11 RegOut", ifA.RegOut, 16'hFFFF);
    chk("A op11 Fault", ifA.Fault, 0);
    ifA.RegWrite = 1'b0;

    // ---------------- saturating, [16,40] step 4 ----------------
    chk("B reset RegOut", ifB.RegOut, 16);
    chk("B reset Empty", ifB.Empty, 1);
    rstB = 1'b0;
    ifB.RegWrite = 1'b1; ifB.Op = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("B up RegOut", ifB.RegOut, 16 + 4 * i);
      chk("B up Fault", ifB.Fault, 0);
      chk("B up Full", ifB.Full, (i == 6) ? 1 : 0);
    end
    tick();
    chk("B sat RegOut", ifB.RegOut, 40);
    chk("B sat Ovf", ifB.Overflow, 1);
    chk("B sat Fault", ifB.Fault, 1);
    ifB.Op = 2'b01;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("B down RegOut", ifB.RegOut, 40 - 4 * i);
      chk("B down Unf", ifB.Underflow, 0);
      chk("B down Fault", ifB.Fault, 0);
    end
    tick();
    chk("B floor RegOut", ifB.RegOut, 16);
    chk("B floor Empty", ifB.Empty, 1);
    chk("B floor Unf", ifB.Underflow, 1);
    chk("B floor Fault", ifB.Fault, 1);
    tick();
    chk("B floor2 Fault cont", ifB.Fault, 1);
    chk("B floor2 RegOut", ifB.RegOut, 16);

    // clear, then loads
    ifB.RegWrite = 1'b0; ifB.ClearFlags = 1'b1;
    tick();
    ifB.ClearFlags = 1'b0;
    chk("B clr Ovf", ifB.Overflow, 0);
    chk("B clr Unf", ifB.Underflow, 0);
    ifB.RegWrite = 1'b1; ifB.Op = 2'b10; ifB.LoadIn = 16'd30;
    tick();
    chk("B ld30 RegOut", ifB.RegOut, 30);
    chk("B ld30 Fault", ifB.Fault, 0);
    ifB.LoadIn = 16'd50;
    tick();
    chk("B ld50 RegOut", ifB.RegOut, 30);
    chk("B ld50 Ovf", ifB.Overflow, 1);
    chk("B ld50 Unf", ifB.Underflow, 0);
    chk("B ld50 Fault", ifB.Fault, 1);
    ifB.LoadIn = 16'd3;
    tick();
    chk("B ld3 RegOut", ifB.RegOut, 30);
    chk("B ld3 Unf", ifB.Underflow, 1);
    chk("B ld3 Fault", ifB.Fault, 1);
    ifB.LoadIn = 16'd40;
    tick();
    chk("B ld40 RegOut", ifB.RegOut, 40);
    chk("B ld40 Fault", ifB.Fault, 0);

    // ClearFlags with an overflowing increment: set wins for Overflow only
    ifB.Op = 2'b00; ifB.ClearFlags = 1'b1;
    tick();
    ifB.ClearFlags = 1'b0; ifB.RegWrite = 1'b0;
    chk("B clrset Ovf", ifB.Overflow, 1);
    chk("B clrset Unf", ifB.Underflow, 0);
    chk("B clrset Fault", ifB.Fault, 1);
    chk("B clrset RegOut", ifB.RegOut, 40);

    // ---------------- wrapping, [16,40] step 4 ----------------
    chk("C reset RegOut", ifC.RegOut, 16);
    rstC = 1'b0;
    ifC.RegWrite = 1'b1; ifC.Op = 2'b01;
    tick();
    chk("C wrapdn RegOut", ifC.RegOut, 37);
    chk("C wrapdn Unf", ifC.Underflow, 1);
    chk("C wrapdn Fault", ifC.Fault, 1);
    ifC.Op = 2'b10; ifC.LoadIn = 16'd40;
    tick();
    chk("C ld40 RegOut", ifC.RegOut, 40);
    chk("C ld40 Fault", ifC.Fault, 0);
    ifC.Op = 2'b00;
    tick();
    chk("C wrapup RegOut", ifC.RegOut, 19);
    chk("C wrapup Ovf", ifC.Overflow, 1);
    chk("C wrapup Fault", ifC.Fault, 1);
    ifC.RegWrite = 1'b0;
    tick();
    chk("C idle Fault", ifC.Fault, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
